// File: rtl/router_fsm_ctrl.sv
// Packet-sequencing FSM for the 1x3 router: decodes the header address, tracks
// FIFO status and drives the one-hot strobes that step router_reg through a packet.
module router_fsm_ctrl (
  input  logic       clock,
  input  logic       reset,
  input  logic       pkt_valid,
  input  logic [1:0] data_in,
  input  logic       fifo_full,
  input  logic [2:0] fifo_empty,
  input  logic [2:0] soft_reset,
  input  logic       parity_done,
  input  logic       low_packet_valid,
  output logic       write_enb_reg,
  output logic       detect_add,
  output logic       lfd_state,
  output logic       ld_state,
  output logic       laf_state,
  output logic       full_state,
  output logic       rst_int_reg,
  output logic       busy,
  output logic [1:0] addr_q,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'd0,
    LOAD_FIRST_DATA    = 3'd1,
    LOAD_DATA          = 3'd2,
    LOAD_PARITY        = 3'd3,
    FIFO_FULL_STATE    = 3'd4,
    LOAD_AFTER_FULL    = 3'd5,
    WAIT_TILL_EMPTY    = 3'd6,
    CHECK_PARITY_ERROR = 3'd7
  } state_t;

  state_t state, state_next;

  // Padded to four entries so address 3 indexes a harmless zero.
  logic [3:0] empty_ext;
  logic [3:0] soft_ext;
  logic       addr_ok;
  logic       addr_load;

  assign empty_ext = {1'b0, fifo_empty};
  assign soft_ext  = {1'b0, soft_reset};
  assign addr_ok   = (data_in != 2'd3);
  assign addr_load = (state == DECODE_ADDRESS) && pkt_valid && addr_ok;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= DECODE_ADDRESS;
      addr_q <= 2'd0;
    end else begin
      state <= state_next;
      if (addr_load) addr_q <= data_in;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      DECODE_ADDRESS: begin
        if (addr_load) begin
          if (empty_ext[data_in]) state_next = LOAD_FIRST_DATA;
          else                    state_next = WAIT_TILL_EMPTY;
        end
      end
      WAIT_TILL_EMPTY: begin
        if (empty_ext[addr_q]) state_next = LOAD_FIRST_DATA;
      end
      LOAD_FIRST_DATA: state_next = LOAD_DATA;
      LOAD_DATA: begin
        if (fifo_full)       state_next = FIFO_FULL_STATE;
        else if (!pkt_valid) state_next = LOAD_PARITY;
      end
      FIFO_FULL_STATE: begin
        if (!fifo_full) state_next = LOAD_AFTER_FULL;
      end
      LOAD_AFTER_FULL: begin
        if (parity_done)           state_next = DECODE_ADDRESS;
        else if (low_packet_valid) state_next = LOAD_PARITY;
        else                       state_next = LOAD_DATA;
      end
      LOAD_PARITY: state_next = CHECK_PARITY_ERROR;
      CHECK_PARITY_ERROR: begin
        if (fifo_full) state_next = FIFO_FULL_STATE;
        else           state_next = DECODE_ADDRESS;
      end
      default: state_next = DECODE_ADDRESS;
    endcase
    // A read timeout on the selected FIFO abandons the packet from any busy state.
    if (state != DECODE_ADDRESS && soft_ext[addr_q]) state_next = DECODE_ADDRESS;
  end

  always_comb begin
    detect_add    = 1'b0;
    lfd_state     = 1'b0;
    ld_state      = 1'b0;
    laf_state     = 1'b0;
    full_state    = 1'b0;
    rst_int_reg   = 1'b0;
    write_enb_reg = 1'b0;
    busy          = 1'b1;
    case (state)
      DECODE_ADDRESS: begin
        detect_add = 1'b1;
        busy       = 1'b0;
      end
      LOAD_FIRST_DATA: lfd_state = 1'b1;
      LOAD_DATA: begin
        ld_state      = 1'b1;
        write_enb_reg = 1'b1;
        busy          = 1'b0;
      end
      LOAD_PARITY: write_enb_reg = 1'b1;
      FIFO_FULL_STATE: full_state = 1'b1;
      LOAD_AFTER_FULL: begin
        laf_state     = 1'b1;
        write_enb_reg = 1'b1;
      end
      CHECK_PARITY_ERROR: rst_int_reg = 1'b1;
      default: ;
    endcase
  end

  assign state_dbg = state;

endmodule
